regfile_scan_reader: RTL

Sequential reader that sits on one read port of the CPU register file and, on command, walks every register from index 0 up to NUM_REGS-1. It captures each register value and presents it on a valid/ready output stream. The debug/trace logic and the testbench dump path consume this stream.

---
 rtl/regfile_scan_reader.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/regfile_scan_reader.sv
// Sequential register-file scanner: on Start it walks registers 0..NUM_REGS-1
// through one combinational read port. Each value is captured in a FETCH cycle
// and then offered on a valid/ready stream during PRESENT.
module regfile_scan_reader #(
    parameter int DATA_WIDTH = 18,
    parameter int ADDR_WIDTH = 4,
    parameter int NUM_REGS   = 16
) (
    input  logic                  Clock,
    input  logic                  Clear,
    input  logic                  Start,
    input  logic                  Abort,
    output logic [ADDR_WIDTH-1:0] ReadSelect,
    input  logic [DATA_WIDTH-1:0] ReadData,
    output logic [DATA_WIDTH-1:0] OutData,
    output logic [ADDR_WIDTH-1:0] OutIndex,
    output logic                  OutValid,
    input  logic                  OutReady,
    output logic                  OutLast,
    output logic                  Busy,
    output logic                  Done
);

    // Terminal index; the scan stops here rather than relying on wrap-around,
    // so NUM_REGS == 2**ADDR_WIDTH cannot emit a phantom extra word.
    localparam logic [ADDR_WIDTH-1:0] LAST_INDEX = ADDR_WIDTH'(NUM_REGS - 1);

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StPresent,
        StDone
    } state_t;

    state_t                  state;
    state_t                  stateNext;
    logic [ADDR_WIDTH-1:0]   scanIndex;
    logic                    startScan;
    logic                    loadWord;
    logic                    advance;
    logic                    finishScan;
    logic                    abortScan;

    // The index is zero whenever the scanner is not walking, so the read port
    // rests at register 0 in IDLE without extra muxing.
    assign ReadSelect = scanIndex;

    // State register.
    always_ff @(posedge Clock) begin
        if (Clear) begin
            state <= StIdle;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state decode plus one-hot strobes for the datapath; Abort outranks OutReady.
    always_comb begin
        stateNext  = state;
        startScan  = 1'b0;
        loadWord   = 1'b0;
        advance    = 1'b0;
        finishScan = 1'b0;
        abortScan  = 1'b0;
        case (state)
            StIdle: begin
                if (Start) begin
                    stateNext = StFetch;
                    startScan = 1'b1;
                end
            end
            StFetch: begin
                if (Abort) begin
                    stateNext = StIdle;
                    abortScan = 1'b1;
                end else begin
                    stateNext = StPresent;
                    loadWord  = 1'b1;
                end
            end
            StPresent: begin
                if (Abort) begin
                    stateNext = StIdle;
                    abortScan = 1'b1;
                end else if (OutReady) begin
                    if (scanIndex == LAST_INDEX) begin
                        stateNext  = StDone;
                        finishScan = 1'b1;
                    end else begin
                        stateNext = StFetch;
                        advance   = 1'b1;
                    end
                end
            end
            StDone: begin
                stateNext = StIdle;
            end
            default: begin
                stateNext = StIdle;
            end
        endcase
    end

    // Scan index: cleared at every scan boundary, bumped once per accepted word.
    always_ff @(posedge Clock) begin
        if (Clear) begin
            scanIndex <= '0;
        end else if (startScan || abortScan || finishScan) begin
            scanIndex <= '0;
        end else if (advance) begin
            scanIndex <= scanIndex + 1'b1;
        end
    end

    // Status flags are registered from the next state, so OutReady never reaches OutValid combinationally.
    always_ff @(posedge Clock) begin
        if (Clear) begin
            OutValid <= 1'b0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
        end else begin
            OutValid <= (stateNext == StPresent);
            Busy     <= (stateNext != StIdle);
            Done     <= (stateNext == StDone);
        end
    end

    // Output word: snapshot of the register file at the FETCH edge, held until accepted.
    always_ff @(posedge Clock) begin
        if (Clear) begin
            OutData  <= '0;
            OutIndex <= '0;
            OutLast  <= 1'b0;
        end else if (loadWord) begin
            OutData  <= ReadData;
            OutIndex <= scanIndex;
            OutLast  <= (scanIndex == LAST_INDEX);
        end else if (abortScan || finishScan) begin
            OutLast  <= 1'b0;
        end
    end

endmodule
